// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU-side bus of the FIFO-buffered UART transmitter.
// Signals are suffixed from the transmitter's point of view:
//   wr_i       write strobe, pushes data_i when full_o=0
//   data_i     word to transmit
//   brk_i      break request (only with UART_TX_BREAK_EN)
//   full_o     FIFO holds FIFO_DEPTH words
//   empty_o    FIFO holds no words
//   count_o    FIFO occupancy
//   busy_o     frame (or break) in progress
//   overrun_o  sticky: a write hit a full FIFO
//   line_out_o serial output, idle high
// master: CPU / testbench side; slave: the transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic                 wr_i;
    logic [DATA_BITS-1:0] data_i;
    logic                 full_o;
    logic                 empty_o;
    logic [CW-1:0]        count_o;
    logic                 busy_o;
    logic                 overrun_o;
    logic                 line_out_o;
`ifdef UART_TX_BREAK_EN
    logic                 brk_i;
    modport master (output wr_i, data_i, brk_i,
                    input  full_o, empty_o, count_o, busy_o, overrun_o, line_out_o);
    modport slave  (input  wr_i, data_i, brk_i,
                    output full_o, empty_o, count_o, busy_o, overrun_o, line_out_o);
`else
    modport master (output wr_i, data_i,
                    input  full_o, empty_o, count_o, busy_o, overrun_o, line_out_o);
    modport slave  (input  wr_i, data_i,
                    output full_o, empty_o, count_o, busy_o, overrun_o, line_out_o);
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with internal baud divider and transmit FIFO.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset; aborts any frame and empties the FIFO
//   bus    uart_tx_fifo_if.slave (write strobe/data in; FIFO status, busy, overrun, line out)
// Frames: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits,
// each bit CLK_FREQ/BAUD clocks. Queued words are sent back-to-back with no idle gap.
// Optional macro UART_TX_BREAK_EN adds bus.brk_i: in IDLE the line is held low while it is
// set, followed by at least one idle bit time before the next frame.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int IW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    state_e               state_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, empty_q, overrun_q;
    logic [BW-1:0]        baud_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] sh_q, head;
    logic                 par_q, line_q, busy_q;
    logic                 push, pop, bit_end, brk_idle, brk_stop;

`ifdef UART_TX_BREAK_EN
    // brk_hold_q covers the break itself plus the idle bit that follows it
    logic brk_hold_q;
    assign brk_stop = bus.brk_i;
    assign brk_idle = bus.brk_i || brk_hold_q;
`else
    assign brk_stop = 1'b0;
    assign brk_idle = 1'b0;
`endif

    assign head    = mem_q[rd_ptr_q];
    assign bit_end = baud_q == BW'(DIV - 1);
    // Full test uses the registered flag, so a same-cycle pop never rescues a write
    assign push    = bus.wr_i && !full_q;
    // Pop from IDLE, or at the end of the last stop bit for a gap-free next frame
    assign pop     = !empty_q && ((state_q == IDLE && !brk_idle) ||
                     (state_q == STOP && bit_end && idx_q == IW'(STOP_BITS - 1) && !brk_stop));
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i)
        if (push) mem_q[wr_ptr_q] <= bus.data_i;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            full_q    <= count_d == CW'(FIFO_DEPTH);
            empty_q   <= count_d == '0;
            if (bus.wr_i && full_q) overrun_q <= 1'b1;
        end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= IDLE;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            baud_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_hold_q <= 1'b0;
`endif
        end else if (pop) begin
            sh_q    <= head;
            par_q   <= (PARITY == 2) ? ^head : ~^head;
            line_q  <= 1'b0;
            busy_q  <= 1'b1;
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= START;
        end else begin
            baud_q <= bit_end ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
`ifdef UART_TX_BREAK_EN
                    if (bus.brk_i) begin
                        line_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        brk_hold_q <= 1'b1;
                    end else if (brk_hold_q) begin
                        line_q <= 1'b1;
                        baud_q <= bit_end ? '0 : baud_q + 1'b1;
                        if (bit_end) begin
                            brk_hold_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end
                    end else
`endif
                    begin
                        line_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: if (bit_end) begin
                    line_q  <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                    idx_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_q   <= '0;
                        line_q  <= (PARITY != 0) ? par_q : 1'b1;
                        state_q <= (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        line_q <= sh_q[0];
                        sh_q   <= sh_q >> 1;
                    end
                end
                PAR: if (bit_end) begin
                    line_q  <= 1'b1;
                    idx_q   <= '0;
                    state_q <= STOP;
                end
                STOP: if (bit_end) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        line_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else
                        idx_q <= idx_q + 1'b1;
                end
                default: begin
                    line_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end

    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.count_o    = count_q;
    assign bus.busy_o     = busy_q;
    assign bus.overrun_o  = overrun_q;
    assign bus.line_out_o = line_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at DIV=10.
// u_a: 8N1 depth 4; u_b: even parity, 2 stop bits; u_c: odd parity, 1 stop bit.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   busy_gaps = 0;
    logic mon_busy = 1'b0;
    logic [2:0] line_w;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ia ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ib ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ic ();

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        u_a (.clk_i(clk), .rst_i(rst), .bus(ia.slave));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(4))
        u_b (.clk_i(clk), .rst_i(rst), .bus(ib.slave));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        u_c (.clk_i(clk), .rst_i(rst), .bus(ic.slave));

    always #5 clk = ~clk;

    assign line_w = {ic.line_out_o, ib.line_out_o, ia.line_out_o};

    always @(negedge clk)
        if (mon_busy && ia.busy_o !== 1'b1) busy_gaps++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input int d, input logic [7:0] w);
        @(negedge clk);
        if (d == 0) begin ia.wr_i = 1'b1; ia.data_i = w; end
        if (d == 1) begin ib.wr_i = 1'b1; ib.data_i = w; end
        if (d == 2) begin ic.wr_i = 1'b1; ic.data_i = w; end
        @(posedge clk);
        #1;
        ia.wr_i = 1'b0;
        ib.wr_i = 1'b0;
        ic.wr_i = 1'b0;
    endtask

    // Waits for the start bit, then checks every clock of every bit of the frame.
    task automatic expect_frame(input int d, input logic [7:0] w, input int par, input int stops,
                                input string tag, output int waited);
        logic       bits [16];
        logic [9:0] v;
        logic       p;
        int         n;
        p = 1'b0;
        for (int i = 0; i < 8; i++) p ^= w[i];
        if (par == 1) p = ~p;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = w[i]; n++; end
        if (par != 0) begin bits[n] = p; n++; end
        for (int i = 0; i < stops; i++) begin bits[n] = 1'b1; n++; end
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (line_w[d] !== 1'b0 && waited < 300);
        if (waited >= 300) begin
            chk({tag, "_start_timeout"}, 32'(line_w[d]), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 10; j++) begin
                if (i != 0 || j != 0) begin
                    @(posedge clk);
                    #1;
                end
                v[j] = line_w[d];
            end
            chk($sformatf("%s_bit%0d", tag, i), 32'(v), 32'({10{bits[i]}}));
        end
    endtask

    initial begin
        int w0, w1, w2, lows;
        ia.wr_i = 1'b0; ia.data_i = '0;
        ib.wr_i = 1'b0; ib.data_i = '0;
        ic.wr_i = 1'b0; ic.data_i = '0;
`ifdef UART_TX_BREAK_EN
        ia.brk_i = 1'b0;
        ib.brk_i = 1'b0;
        ic.brk_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_line", 32'(ia.line_out_o), 32'd1);
        chk("rst_busy", 32'(ia.busy_o), 32'd0);
        chk("rst_full", 32'(ia.full_o), 32'd0);
        chk("rst_empty", 32'(ia.empty_o), 32'd1);
        chk("rst_count", 32'(ia.count_o), 32'd0);
        chk("rst_overrun", 32'(ia.overrun_o), 32'd0);

        // 8N1 0xA5: start bit begins one edge after the write edge
        wr_word(0, 8'hA5);
        chk("a5_count_after_wr", 32'(ia.count_o), 32'd1);
        chk("a5_empty_after_wr", 32'(ia.empty_o), 32'd0);
        expect_frame(0, 8'hA5, 0, 1, "a5_8n1", w0);
        chk("a5_start_latency", 32'(w0), 32'd1);
        chk("a5_busy_last_stop", 32'(ia.busy_o), 32'd1);
        @(posedge clk); #1;
        chk("a5_busy_fall", 32'(ia.busy_o), 32'd0);
        chk("a5_line_idle", 32'(ia.line_out_o), 32'd1);

        // Even parity + 2 stop bits: 120-clock frame, parity 0 for 0xA5
        wr_word(1, 8'hA5);
        expect_frame(1, 8'hA5, 2, 2, "a5_8e2", w0);
        chk("8e2_start_latency", 32'(w0), 32'd1);
        @(posedge clk); #1;
        chk("8e2_busy_fall", 32'(ib.busy_o), 32'd0);

        // Odd parity: 0xA5 -> 1, 0x07 -> 0
        wr_word(2, 8'hA5);
        expect_frame(2, 8'hA5, 1, 1, "a5_8o1", w0);
        wr_word(2, 8'h07);
        expect_frame(2, 8'h07, 1, 1, "07_8o1", w0);

        // Back-to-back: three consecutive writes, no idle gap, BUSY held
        fork
            begin
                wr_word(0, 8'h01);
                wr_word(0, 8'h02);
                wr_word(0, 8'h03);
            end
            begin
                expect_frame(0, 8'h01, 0, 1, "b2b_01", w0);
                mon_busy = 1'b1;
                expect_frame(0, 8'h02, 0, 1, "b2b_02", w1);
                chk("b2b_count_mid", 32'(ia.count_o), 32'd1);
                expect_frame(0, 8'h03, 0, 1, "b2b_03", w2);
                chk("b2b_empty_end", 32'(ia.empty_o), 32'd1);
                mon_busy = 1'b0;
            end
        join
        chk("b2b_gap_2", 32'(w1), 32'd1);
        chk("b2b_gap_3", 32'(w2), 32'd1);
        chk("b2b_busy_gaps", 32'(busy_gaps), 32'd0);
        @(posedge clk); #1;
        chk("b2b_busy_fall", 32'(ia.busy_o), 32'd0);

        // Depth-4 fill: six writes -> 1 popped, 4 stored, 1 dropped
        fork
            begin
                wr_word(0, 8'h11);
                wr_word(0, 8'h22);
                wr_word(0, 8'h33);
                wr_word(0, 8'h44);
                wr_word(0, 8'h55);
                chk("fill_full_at4", 32'(ia.full_o), 32'd1);
                chk("fill_overrun_pre", 32'(ia.overrun_o), 32'd0);
                wr_word(0, 8'h66);
                chk("fill_count", 32'(ia.count_o), 32'd4);
                chk("fill_overrun", 32'(ia.overrun_o), 32'd1);
            end
            begin
                expect_frame(0, 8'h11, 0, 1, "fill_11", w0);
                expect_frame(0, 8'h22, 0, 1, "fill_22", w0);
                expect_frame(0, 8'h33, 0, 1, "fill_33", w0);
                expect_frame(0, 8'h44, 0, 1, "fill_44", w0);
                expect_frame(0, 8'h55, 0, 1, "fill_55", w0);
            end
        join
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ia.line_out_o !== 1'b1) lows++;
        end
        chk("fill_no_sixth_frame", 32'(lows), 32'd0);
        chk("fill_empty_end", 32'(ia.empty_o), 32'd1);
        chk("fill_overrun_sticky", 32'(ia.overrun_o), 32'd1);

        // Reset at cycle 35 of a frame (data bit 2 of 0x5A is 0), one word still queued
        wr_word(0, 8'h5A);
        wr_word(0, 8'h5B);
        repeat (34) @(posedge clk);
        #2;
        chk("rstmid_line_before", 32'(ia.line_out_o), 32'd0);
        chk("rstmid_count_before", 32'(ia.count_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_line", 32'(ia.line_out_o), 32'd1);
        chk("rstmid_count", 32'(ia.count_o), 32'd0);
        chk("rstmid_busy", 32'(ia.busy_o), 32'd0);
        chk("rstmid_overrun", 32'(ia.overrun_o), 32'd0);
        chk("rstmid_empty", 32'(ia.empty_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_still_idle", 32'(ia.line_out_o), 32'd1);
        wr_word(0, 8'hC3);
        expect_frame(0, 8'hC3, 0, 1, "post_rst_c3", w0);
        chk("post_rst_latency", 32'(w0), 32'd1);

`ifdef UART_TX_BREAK_EN
        // Break for 50 clocks with a word queued, then >= 1 idle bit, then the frame
        @(posedge clk);
        @(negedge clk);
        ia.brk_i = 1'b1;
        ia.wr_i = 1'b1;
        ia.data_i = 8'h96;
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            ia.wr_i = 1'b0;
            if (ia.line_out_o === 1'b0) lows++;
            if (i == 25) chk("brk_busy", 32'(ia.busy_o), 32'd1);
            if (i == 25) chk("brk_count_held", 32'(ia.count_o), 32'd1);
        end
        ia.brk_i = 1'b0;
        chk("brk_low_clocks", 32'(lows), 32'd50);
        expect_frame(0, 8'h96, 0, 1, "brk_frame_96", w0);
        chk("brk_idle_bit", 32'(w0 >= 11), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
